apb_regfile_completer: RTL
==========================

# apb_regfile_completer

Parametrised APB4 completer: a byte-strobed register file of NUM_REGS words with programmable wait states and PSLVERR error signalling. It is the next generation of the APB peripheral side, generalised in data width, register depth and response latency. It sits behind the APB requester on the shared bus and uses the `apb_pkg` state encoding and alignment check.

## Interface
- ADDR_WIDTH, 16, PADDR width in bits (byte address).
- DATA_WIDTH, 32, PWDATA/PRDATA width; legal values 8, 16, 32.
- NUM_REGS, 16, number of implemented words; must be ≤ 2**(ADDR_WIDTH-ALIGNBITS).
- WAIT_CYCLES, 0, wait states inserted per transfer (0..15).
- PCLK  in  1  bus clock; all logic rises on its rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- PSEL  in  1  completer select.
- PENABLE  in  1  access-phase marker.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  byte-lane write strobes.
- PRDATA  out  DATA_WIDTH  read data, registered.
- PREADY  out  1  transfer-complete, registered.
- PSLVERR  out  1  error response, registered; meaningful only while PREADY=1.

## Operation
- The FSM uses `apb_pkg::state`: IDLE, SETUP, ACCESS, ERROR.
- The word index is PADDR[ADDR_WIDTH-1:ALIGNBITS].
- Transfer start: in IDLE or SETUP, with PSEL=1 and PENABLE=0, the rising edge latches PWRITE, the index and PSTRB, and runs the error check.
  - If the check passes, the next state is ACCESS; otherwise it is ERROR.
- Error conditions (any one is sufficient):
  - `validAlign(PADDR)` is false.
  - index ≥ NUM_REGS.
  - the transfer is a read with PSTRB ≠ 0.
- ACCESS and ERROR both use the wait counter.
  - The counter is loaded with WAIT_CYCLES at the start edge.
  - It decrements on each access cycle while PREADY=0.
  - PREADY is set on the edge where the counter goes from 1 to 0, or at the start edge if WAIT_CYCLES=0.
- Completion edge (PSEL, PENABLE and PREADY all 1):
  - A valid write updates only the bytes whose PSTRB bit is 1.
  - PREADY and PSLVERR clear at this edge.
  - The state moves to SETUP if PSEL=1 and PENABLE=0 are already presented; otherwise it moves to IDLE.
- Reads:
  - PRDATA loads the addressed word at the start edge and holds until the next read start.
  - An errored read loads PRDATA = 0.
- ERROR state:
  - PSLVERR is set together with PREADY.
  - A write does not modify the register file.
- Abort: if PSEL=0 while in ACCESS or ERROR before completion, the FSM goes to IDLE, PREADY and PSLVERR clear, and no write occurs.
- Back-to-back transfers need no idle cycle between them.

## Timing
- Reset (PRESET=1, asynchronous, at any time including mid-transfer):
  - PRDATA=0, PREADY=0, PSLVERR=0.
  - All registers = 0, counter = 0, state = IDLE.
  - After release, the first start edge behaves normally.
- Zero-wait transfer: setup cycle + 1 access cycle, with PREADY high in that first access cycle.
- With N wait states, PREADY rises in access cycle N+1.
- A write is visible to a read whose setup phase begins on the cycle after the write completes.
- PENABLE=1 seen in IDLE (protocol violation) is ignored; the state stays IDLE.

## Configuration
- `APB_WAIT_EN` defined: the WAIT_CYCLES counter is implemented and honoured.
- `APB_WAIT_EN` undefined: the counter is not synthesised, WAIT_CYCLES is ignored, and every transfer is zero-wait.

## Structure
- `apb_pkg` holds:
  - the `state` enum.
  - ADDR_WIDTH, DATA_WIDTH, STRB_WIDTH, ALIGNBITS.
  - `validAlign`.
  - a new `MAX_WAIT = 15` constant.
  - a new typedef `resp_t` {OKAY, SLVERR}.
- Sub-module `apb_regfile`:
  - NUM_REGS×DATA_WIDTH array.
  - byte-strobed write port.
  - combinational read port.
  - asynchronous clear on PRESET.
- The top level contains the FSM, the error check, the wait counter and the output registers.

## Test plan
- Reset: assert PRESET mid-idle, then release → PRDATA=0, PREADY=0, PSLVERR=0; read of 0x0000 returns 0.
- Zero-wait write then read: write 0xDEADBEEF to 0x0004 with PSTRB=4'hF, then read 0x0004 → PREADY in the first access cycle, PRDATA=0xDEADBEEF, PSLVERR=0.
- Strobed write: write 0x0000AB00 to 0x0004 with PSTRB=4'b0010 → readback is 0xDEADABEF.
- Misaligned and out-of-range addresses:
  - write to 0x0006 → PSLVERR=1 with PREADY; 0x0004 is unchanged.
  - read of 0x0040 (index 16) → PSLVERR=1, PRDATA=0.
- Wait states: WAIT_CYCLES=3 → with `APB_WAIT_EN`, PREADY in access cycle 4; without it, PREADY in access cycle 1.
- Reset mid-transfer: pulse PRESET during wait cycle 2 of a write to 0x0008 → PREADY=0 at once; 0x0008 reads 0; the next transfer completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer FSM states, bus geometry defaults, response codes and the alignment check.
package apb_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ALIGNBITS  = $clog2(STRB_WIDTH);
  localparam int MAX_WAIT   = 15;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERROR} state;
  typedef enum logic {OKAY, SLVERR} resp_t;

  // True when the byte address sits on a word boundary of a (1 << alignBits)-byte bus.
  function automatic logic validAlign(input logic [31:0] addr, input int alignBits = ALIGNBITS);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < alignBits && addr[i]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/apb_regfile.sv
// Register array: byte-strobed synchronous write, combinational read (zero beyond NUM_REGS), async clear.
// Writes land on the PCLK edge where wrEn is high; no backpressure.
module apb_regfile #(
  parameter int NUM_REGS   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 4
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    wrEn,
  input  logic [IDX_W-1:0]        wrIdx,
  input  logic [DATA_WIDTH-1:0]   wrData,
  input  logic [DATA_WIDTH/8-1:0] wrStrb,
  input  logic [IDX_W-1:0]        rdIdx,
  output logic [DATA_WIDTH-1:0]   rdData
);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wrEn) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (wrStrb[b]) mem[wrIdx][b*8 +: 8] <= wrData[b*8 +: 8];
      end
    end
  end

  assign rdData = (int'(rdIdx) < NUM_REGS) ? mem[rdIdx] : '0;

endmodule

// File: rtl/apb_regfile_completer.sv
// APB4 completer over a byte-strobed register file; PSLVERR on misaligned, out-of-range or strobed-read access.
// `APB_WAIT_EN` honours WAIT_CYCLES (PREADY in access cycle WAIT_CYCLES+1), else zero-wait; PSEL drop aborts.
module apb_regfile_completer #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);
  import apb_pkg::*;

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int ALIGN_W = $clog2(STRB_W);
  localparam int IDX_W   = ADDR_WIDTH - ALIGN_W;
  localparam int REG_AW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

`ifdef APB_WAIT_EN
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > MAX_WAIT) ? MAX_WAIT : WAIT_CYCLES);
  localparam logic       ZERO_WAIT = (WAIT_LOAD == 4'd0);
  logic [3:0] waitCnt;
`else
  localparam logic       ZERO_WAIT = 1'b1;
`endif

  state              curState;
  resp_t             respQ;
  logic              wrQ;
  logic [REG_AW-1:0] idxQ;
  logic [STRB_W-1:0] strbQ;
  logic [IDX_W-1:0]  addrIdx;
  logic [DATA_WIDTH-1:0] rdData;
  logic startXfer, reqErr, complete, regWrEn;

  assign addrIdx   = PADDR[ADDR_WIDTH-1:ALIGN_W];
  assign startXfer = PSEL && !PENABLE && (curState == IDLE || curState == SETUP);
  assign reqErr    = !validAlign(32'(PADDR), ALIGN_W)
                  || ({1'b0, addrIdx} >= (IDX_W+1)'(NUM_REGS))
                  || (!PWRITE && |PSTRB);
  assign complete  = PSEL && PENABLE && PREADY && (curState == ACCESS || curState == ERROR);
  assign regWrEn   = complete && curState == ACCESS && wrQ;
  assign PSLVERR   = (respQ == SLVERR);

  apb_regfile #(
    .NUM_REGS  (NUM_REGS),
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (REG_AW)
  ) u_regfile (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .wrEn  (regWrEn),
    .wrIdx (idxQ),
    .wrData(PWDATA),
    .wrStrb(strbQ),
    .rdIdx (addrIdx[REG_AW-1:0]),
    .rdData(rdData)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      curState <= IDLE;
      respQ    <= OKAY;
      PREADY   <= 1'b0;
      PRDATA   <= '0;
      wrQ      <= 1'b0;
      idxQ     <= '0;
      strbQ    <= '0;
`ifdef APB_WAIT_EN
      waitCnt  <= '0;
`endif
    end else begin
      case (curState)
        IDLE, SETUP: begin
          if (startXfer) begin
            wrQ      <= PWRITE;
            idxQ     <= addrIdx[REG_AW-1:0];
            strbQ    <= PSTRB;
            curState <= reqErr ? ERROR : ACCESS;
            PREADY   <= ZERO_WAIT;
            respQ    <= (ZERO_WAIT && reqErr) ? SLVERR : OKAY;
            if (!PWRITE) PRDATA <= reqErr ? '0 : rdData;
`ifdef APB_WAIT_EN
            waitCnt  <= WAIT_LOAD;
`endif
          end else begin
            curState <= IDLE;
          end
        end
        default: begin
          if (!PSEL) begin
            curState <= IDLE;
            PREADY   <= 1'b0;
            respQ    <= OKAY;
          end else if (complete) begin
            // PENABLE is high here, so a following setup phase is always picked up from IDLE.
            curState <= IDLE;
            PREADY   <= 1'b0;
            respQ    <= OKAY;
          end else if (!PREADY) begin
`ifdef APB_WAIT_EN
            if (waitCnt != 4'd0) waitCnt <= waitCnt - 4'd1;
            if (waitCnt == 4'd1) begin
              PREADY <= 1'b1;
              respQ  <= (curState == ERROR) ? SLVERR : OKAY;
            end
`endif
          end
        end
      endcase
    end
  end

endmodule
